// File: rtl/fetch_pc_if.sv
// fetch_pc_if: control inputs and PC/status outputs of the fetch_pc block.
// The master drives the control inputs; the slave (fetch_pc) drives PC, halt and ras_err.
interface fetch_pc_if #(
    parameter int PC_W  = 10,
    parameter int OFS_W = 8
);
    logic             stall;
    logic             restart;
    logic             branch_en;
    logic             bSIGN;
    logic [OFS_W-1:0] bOFFSET;
    logic             jump_en;
    logic [PC_W-1:0]  jTARGET;
    logic             call_en;
    logic             ret_en;
    logic [PC_W-1:0]  PC;
    logic             halt;
    logic             ras_err;

    modport master (
        output stall, restart, branch_en, bSIGN, bOFFSET,
        output jump_en, jTARGET, call_en, ret_en,
        input  PC, halt, ras_err
    );

    modport slave (
        input  stall, restart, branch_en, bSIGN, bOFFSET,
        input  jump_en, jTARGET, call_en, ret_en,
        output PC, halt, ras_err
    );
endinterface

// File: rtl/fetch_pc.sv
// fetch_pc: program-counter sequencer with relative branch, absolute jump,
// optional return-address stack and a sticky halt state.
// Build option: define FETCH_PC_RAS_EN to include the return-address stack,
// call/return handling and the ras_err flag. Without it call_en/ret_en are
// accepted but ignored and ras_err reads 0.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_RUN  | PC advances every unstalled cycle by the next-PC priority
// ST_HALT | PC reached HALT_ADDR; everything frozen until restart/reset
module fetch_pc #(
    parameter int PC_W       = 10,
    parameter int OFS_W      = 8,
    parameter int RAS_DEPTH  = 4,
    parameter int START_ADDR = 0,
    parameter int HALT_ADDR  = 63
) (
    input logic       CLK,
    input logic       init_n,
    fetch_pc_if.slave bus
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);
    localparam logic [PC_W-1:0] HALT_PC  = PC_W'(HALT_ADDR);

    logic [0:0]      state_q;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_nxt;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] pc_br;
    logic [PC_W-1:0] ofs_ext;
    logic            advance;

    assign ofs_ext = {{(PC_W-OFS_W){1'b0}}, bus.bOFFSET};
    assign pc_inc  = pc_q + PC_W'(1);
    assign pc_br   = bus.bSIGN ? (pc_q - ofs_ext) : (pc_q + ofs_ext);

    // A new PC is taken only when running, not stalled, and no restart pending.
    assign advance = (state_q == ST_RUN) && !bus.stall && !bus.restart;

`ifdef FETCH_PC_RAS_EN
    localparam int IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = IDX_W + 1;

    logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
    logic [CNT_W-1:0] ras_cnt;
    logic [IDX_W-1:0] push_idx;
    logic [IDX_W-1:0] top_idx;
    logic [PC_W-1:0]  ras_top;
    logic             ras_empty;
    logic             ras_full;
    logic             ras_push;
    logic             ras_pop;
    logic             ras_err_set;
    logic             ras_err_q;

    // The stack grows upward; ras_cnt is both depth and next free slot.
    assign push_idx  = ras_cnt[IDX_W-1:0];
    assign top_idx   = push_idx - IDX_W'(1);
    assign ras_top   = ras_mem[top_idx];
    assign ras_empty = (ras_cnt == '0);
    assign ras_full  = (ras_cnt == CNT_W'(RAS_DEPTH));
`else
    logic unused_ras_inputs;
    assign unused_ras_inputs = bus.call_en ^ bus.ret_en;
`endif

    // Next-PC selection: ret > call > jump > branch > increment.
    always_comb begin
        pc_nxt = pc_inc;
`ifdef FETCH_PC_RAS_EN
        ras_push    = 1'b0;
        ras_pop     = 1'b0;
        ras_err_set = 1'b0;
        if (bus.ret_en) begin
            if (ras_empty) begin
                pc_nxt      = pc_inc;
                ras_err_set = advance;
            end else begin
                pc_nxt  = ras_top;
                ras_pop = advance;
            end
        end else if (bus.call_en) begin
            pc_nxt = bus.jTARGET;
            if (ras_full) begin
                ras_err_set = advance;
            end else begin
                ras_push = advance;
            end
        end else
`endif
        if (bus.jump_en) begin
            pc_nxt = bus.jTARGET;
        end else if (bus.branch_en) begin
            pc_nxt = pc_br;
        end else begin
            pc_nxt = pc_inc;
        end
    end

    // PC and run/halt state; a halt only ever comes from a computed next-PC,
    // so a START_ADDR equal to HALT_ADDR never halts on reset or restart.
    always_ff @(posedge CLK or negedge init_n) begin
        if (!init_n) begin
            pc_q    <= START_PC;
            state_q <= ST_RUN;
        end else if (bus.restart) begin
            pc_q    <= START_PC;
            state_q <= ST_RUN;
        end else if (advance) begin
            pc_q <= pc_nxt;
            if (pc_nxt == HALT_PC) begin
                state_q <= ST_HALT;
            end
        end
    end

`ifdef FETCH_PC_RAS_EN
    // Stack depth and sticky error flag; restart and reset empty the stack.
    always_ff @(posedge CLK or negedge init_n) begin
        if (!init_n) begin
            ras_cnt   <= '0;
            ras_err_q <= 1'b0;
        end else if (bus.restart) begin
            ras_cnt   <= '0;
            ras_err_q <= 1'b0;
        end else begin
            if (ras_push) begin
                ras_cnt <= ras_cnt + CNT_W'(1);
            end else if (ras_pop) begin
                ras_cnt <= ras_cnt - CNT_W'(1);
            end
            if (ras_err_set) begin
                ras_err_q <= 1'b1;
            end
        end
    end

    // Stack storage; entries above ras_cnt are dead, so no reset is needed.
    always_ff @(posedge CLK) begin
        if (ras_push) begin
            ras_mem[push_idx] <= pc_inc;
        end
    end

    assign bus.ras_err = ras_err_q;
`else
    assign bus.ras_err = 1'b0;
`endif

    assign bus.PC   = pc_q;
    assign bus.halt = (state_q == ST_HALT);

endmodule

// File: tb/tb_fetch_pc.sv
// tb_fetch_pc: directed and random stimulus for fetch_pc, checked against a
// behavioural model using integer arithmetic and a queue for the stack.
module tb_fetch_pc;
    localparam int PC_W      = 10;
    localparam int OFS_W     = 8;
    localparam int RAS_DEPTH = 4;
    localparam int START     = 0;
    localparam int HALT      = 63;
    localparam int MODV      = 1 << PC_W;

    logic CLK    = 1'b0;
    logic init_n = 1'b0;

    always #5 CLK = ~CLK;

    fetch_pc_if #(.PC_W(PC_W), .OFS_W(OFS_W)) bus ();

    fetch_pc #(
        .PC_W(PC_W), .OFS_W(OFS_W), .RAS_DEPTH(RAS_DEPTH),
        .START_ADDR(START), .HALT_ADDR(HALT)
    ) dut (
        .CLK(CLK),
        .init_n(init_n),
        .bus(bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    int m_pc   = START;
    bit m_halt = 1'b0;
    bit m_err  = 1'b0;
    int m_stk[$];

    task automatic model_reset();
        m_pc   = START;
        m_halt = 1'b0;
        m_err  = 1'b0;
        m_stk.delete();
    endtask

    task automatic model_step(input logic st, input logic rs, input logic br, input logic bs,
                              input logic [OFS_W-1:0] bo, input logic jp,
                              input logic [PC_W-1:0] jt, input logic ce, input logic re);
        int nxt;
        logic unused_cr;
        unused_cr = ce ^ re;
        if (rs) begin
            model_reset();
        end else if (!m_halt && !st) begin
            nxt = -1;
`ifdef FETCH_PC_RAS_EN
            if (re) begin
                if (m_stk.size() == 0) begin
                    m_err = 1'b1;
                    nxt   = (m_pc + 1) % MODV;
                end else begin
                    nxt = m_stk.pop_back();
                end
            end else if (ce) begin
                if (m_stk.size() == RAS_DEPTH) m_err = 1'b1;
                else m_stk.push_back((m_pc + 1) % MODV);
                nxt = int'(jt);
            end
`endif
            if (nxt < 0) begin
                if (jp) nxt = int'(jt);
                else if (br) nxt = bs ? (m_pc - int'(bo) + MODV) % MODV : (m_pc + int'(bo)) % MODV;
                else nxt = (m_pc + 1) % MODV;
            end
            m_pc = nxt;
            if (nxt == HALT) m_halt = 1'b1;
        end
    endtask

    task automatic check(input string tag);
        logic [PC_W-1:0] exp_pc;
        exp_pc = m_pc[PC_W-1:0];
        vectors++;
        assert (bus.PC === exp_pc) else begin
            miscompares++;
            $error("FAIL %s pc: observed %0d expected %0d", tag, bus.PC, exp_pc);
        end
        vectors++;
        assert (bus.halt === m_halt) else begin
            miscompares++;
            $error("FAIL %s halt: observed %b expected %b", tag, bus.halt, m_halt);
        end
        vectors++;
        assert (bus.ras_err === m_err) else begin
            miscompares++;
            $error("FAIL %s ras_err: observed %b expected %b", tag, bus.ras_err, m_err);
        end
    endtask

    // Drive at the falling edge, let the rising edge act, then compare.
    task automatic step(input logic st, input logic rs, input logic br, input logic bs,
                        input logic [OFS_W-1:0] bo, input logic jp,
                        input logic [PC_W-1:0] jt, input logic ce, input logic re,
                        input string tag);
        @(negedge CLK);
        bus.stall     = st;
        bus.restart   = rs;
        bus.branch_en = br;
        bus.bSIGN     = bs;
        bus.bOFFSET   = bo;
        bus.jump_en   = jp;
        bus.jTARGET   = jt;
        bus.call_en   = ce;
        bus.ret_en    = re;
        @(posedge CLK);
        model_step(st, rs, br, bs, bo, jp, jt, ce, re);
        #1;
        check(tag);
    endtask

    task automatic idle(input string tag);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, tag);
    endtask

    task automatic jump(input logic [PC_W-1:0] t, input string tag);
        step(0, 0, 0, 0, 0, 1, t, 0, 0, tag);
    endtask

    // Reset pulse wholly between two rising edges, called just after a step.
    task automatic rst_pulse(input string tag);
        #1 init_n = 1'b0;
        #1 model_reset();
        check(tag);
        #1 init_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.stall     = 0;
        bus.restart   = 0;
        bus.branch_en = 0;
        bus.bSIGN     = 0;
        bus.bOFFSET   = '0;
        bus.jump_en   = 0;
        bus.jTARGET   = '0;
        bus.call_en   = 0;
        bus.ret_en    = 0;
        init_n        = 0;
        #3;
        model_reset();
        check("reset_async");
        repeat (2) @(posedge CLK);
        #1;
        check("reset_held");
        init_n = 1'b1;

        repeat (5) idle("inc");

        jump(20, "jmp20");
        step(0, 0, 1, 1, 8'd25, 0, 0, 0, 0, "br_neg_wrap");
        jump(20, "jmp20b");
        step(0, 0, 1, 0, 8'd43, 0, 0, 0, 0, "br_to_halt");
        repeat (3) step(0, 0, 1, 0, 8'd3, 1, 10'd5, 1, 1, "halt_hold");
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, "restart_halt");

        jump(12, "jmp12");
        repeat (3) step(1, 0, 0, 0, 0, 1, 10'd200, 1, 1, "stall_hold");
        idle("after_stall");
        step(1, 1, 0, 0, 0, 1, 10'd200, 0, 0, "restart_over_stall");

        jump(10, "jmp10");
        step(0, 0, 0, 0, 0, 0, 10'd100, 1, 0, "call100");
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, "ret");
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, 0, 0, PC_W'(100 + 10 * i), 1, 0, "nested_call");
        end
        step(0, 0, 0, 0, 0, 0, 10'd400, 1, 1, "call_ret_both");
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, "restart_clr");

        jump(7, "jmp7");
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, "ret_empty");
        repeat (3) idle("err_sticky");
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, "err_clear");

        step(0, 0, 0, 0, 0, 0, 10'd300, 1, 0, "call_before_rst");
        rst_pulse("rst_mid_call");
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, "ret_after_rst");

        jump(30, "jmp30");
        rst_pulse("async_rst_pc30");
        idle("after_async_rst");

        for (int i = 0; i < 400; i++) begin
            logic st, rs, br, bs, jp, ce, re;
            logic [OFS_W-1:0] bo;
            logic [PC_W-1:0] jt;
            st = ($urandom % 8) == 0;
            rs = ($urandom % 24) == 0;
            br = ($urandom % 3) == 0;
            bs = $urandom % 2;
            bo = OFS_W'($urandom);
            jp = ($urandom % 4) == 0;
            jt = (($urandom % 6) == 0) ? PC_W'(HALT) : PC_W'($urandom);
            ce = ($urandom % 5) == 0;
            re = ($urandom % 5) == 0;
            step(st, rs, br, bs, bo, jp, jt, ce, re, "random");
            if (($urandom % 60) == 0) rst_pulse("random_rst");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fetch_pc.md
FETCH_PC -- requirements
Module: fetch_pc

Interface
REQ-001 The block SHALL have parameter PC_W, default 10, meaning program-counter width in bits.
REQ-002 The block SHALL have parameter OFS_W, default 8, meaning branch-offset magnitude width (OFS_W < PC_W).
REQ-003 The block SHALL have parameter RAS_DEPTH, default 4, meaning return-address-stack entries (power of two, >= 2).
REQ-004 The block SHALL have parameter START_ADDR, default 0, meaning PC value after reset or restart.
REQ-005 The block SHALL have parameter HALT_ADDR, default 63, meaning the PC value that enters the halted state.
REQ-006 The block SHALL have port CLK, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-007 The block SHALL have port init_n, input, 1 bit, asynchronous active-low reset.
REQ-008 The block SHALL have port stall, input, 1 bit: hold PC and stack this cycle.
REQ-009 The block SHALL have port restart, input, 1 bit: synchronous return to START_ADDR from any state.
REQ-010 The block SHALL have ports branch_en (1 bit), bSIGN (1 bit) and bOFFSET (OFS_W bits), all inputs: relative branch, sign-magnitude offset.
REQ-011 The block SHALL have ports jump_en (1 bit) and jTARGET (PC_W bits), both inputs: absolute jump.
REQ-012 The block SHALL have ports call_en (1 bit) and ret_en (1 bit), both inputs: subroutine call to jTARGET, and return.
REQ-013 The block SHALL have output PC, PC_W bits, registered current program counter.
REQ-014 The block SHALL have output halt, 1 bit, registered, high while in the HALTED state.
REQ-015 The block SHALL have output ras_err, 1 bit, registered and sticky, flagging stack overflow or underflow.

Function
REQ-016 The state machine SHALL have two states, RUN and HALTED.
REQ-017 In RUN, the next-PC priority SHALL be: restart > stall > ret_en > call_en > jump_en > branch_en > increment.
REQ-018 Increment SHALL compute PC+1; branch SHALL compute PC-zext(bOFFSET) when bSIGN=1, else PC+zext(bOFFSET); all PC arithmetic SHALL be modulo 2^PC_W (wraps silently).
REQ-019 A jump SHALL load PC<=jTARGET.
REQ-020 A call SHALL push PC+1 (mod 2^PC_W) and load PC<=jTARGET in the same cycle.
REQ-021 A call when the stack already holds RAS_DEPTH entries SHALL discard the push, set ras_err, and still load jTARGET.
REQ-022 A ret SHALL pop the top entry into PC.
REQ-023 A ret on an empty stack SHALL set ras_err and load PC<=PC+1.
REQ-024 When call_en and ret_en are both high, ret SHALL take effect and call SHALL be ignored, per REQ-017.
REQ-025 While stall=1 in RUN, PC, the stack and the state SHALL be unchanged and all control inputs ignored.
REQ-026 When the selected next-PC equals HALT_ADDR, PC SHALL load HALT_ADDR and the state SHALL become HALTED at that same edge, so halt rises together with PC==HALT_ADDR.
REQ-027 In HALTED, PC and the stack SHALL hold and all inputs except restart and init_n SHALL be ignored.
REQ-028 restart=1 SHALL, at the next edge, set PC<=START_ADDR, empty the stack, clear ras_err, enter RUN, and override stall and the HALTED state.
REQ-029 START_ADDR equal to HALT_ADDR SHALL NOT cause a halt at reset or restart; only a computed next-PC (REQ-026) halts.

Reset
REQ-030 init_n=0 SHALL asynchronously force PC=START_ADDR, halt=0, ras_err=0, stack empty, state=RUN, independent of CLK.
REQ-031 Deassertion of init_n SHALL take effect at the next rising CLK edge; the first update after release follows REQ-017.
REQ-032 Reset asserted mid-call or mid-halt SHALL discard all stack contents and leave no partial update.

Configuration
REQ-033 Macro FETCH_PC_RAS_EN, when defined, SHALL compile in the return-address stack, call_en/ret_en behaviour and ras_err.
REQ-034 Without FETCH_PC_RAS_EN, call_en and ret_en SHALL still exist but be ignored, ras_err SHALL be tied to 0, and no stack storage SHALL exist.

Verification
REQ-035 Reset then 5 idle cycles -> PC steps 0,1,2,3,4,5; halt=0.
REQ-036 At PC=20, branch_en=1, bSIGN=1, bOFFSET=25 -> PC=1019 (wrap at PC_W=10); at PC=20, bSIGN=0, bOFFSET=43 -> PC=63, halt=1, PC then holds at 63 for 3 cycles.
REQ-037 (RAS_EN) Call to 100 from PC=10 -> PC=100; ret -> PC=11; 5 nested calls with RAS_DEPTH=4 -> ras_err=1 on the 5th call while PC still reaches its target.
REQ-038 (RAS_EN) ret on an empty stack at PC=7 -> PC=8, ras_err=1, and ras_err stays 1 until restart.
REQ-039 Stall held 3 cycles at PC=12 with jump_en=1 -> PC stays 12; in HALTED, restart=1 -> PC=0, halt=0, ras_err=0 next cycle.
REQ-040 init_n pulsed low between clock edges while PC=30 -> PC=0 immediately, without waiting for a CLK edge.
